// File: rtl/alu_pkg.sv
// alu_pkg: shared types and encodings for the ALU decode/execute unit.
//   alu_ctl_t - decoded operation
//   state_t   - sequencer state (IDLE, GCD, LCM, DONE)
//   ALUOP_*   - 2-bit ALUOp encodings
//   FUNCT3_*  - funct3 encodings for R/I-type and coprocessor ops
package alu_pkg;

  typedef enum logic [3:0] {
    ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, GCD, LCM, ILL
  } alu_ctl_t;

  // S_ prefix keeps these clear of the GCD/LCM op names above
  typedef enum logic [1:0] {S_IDLE, S_GCD, S_LCM, S_DONE} state_t;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam logic [1:0] ALUOP_RI  = 2'b10;
  localparam logic [1:0] ALUOP_COP = 2'b11;

  localparam logic [2:0] FUNCT3_ADD  = 3'b000;
  localparam logic [2:0] FUNCT3_SLL  = 3'b001;
  localparam logic [2:0] FUNCT3_SLT  = 3'b010;
  localparam logic [2:0] FUNCT3_SLTU = 3'b011;
  localparam logic [2:0] FUNCT3_XOR  = 3'b100;
  localparam logic [2:0] FUNCT3_SR   = 3'b101;
  localparam logic [2:0] FUNCT3_OR   = 3'b110;
  localparam logic [2:0] FUNCT3_AND  = 3'b111;
  localparam logic [2:0] FUNCT3_GCD  = 3'b000;
  localparam logic [2:0] FUNCT3_LCM  = 3'b001;

endpackage

// File: rtl/alu_ctl_dec.sv
// alu_ctl_dec: combinational decode of ALUOp/funct3/funct7b5/opb5 to alu_ctl_t.
//   aluop, funct3, funct7b5, opb5 -> ctl
// Build option: ALU_GCD_LCM_EN enables GCD/LCM decode on ALUOp=11;
// without it every coprocessor op decodes as ILL.
module alu_ctl_dec
  import alu_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       opb5,
  output alu_ctl_t   ctl
);

  always_comb begin
    ctl = ILL;
    case (aluop)
      ALUOP_ADD: ctl = ADD;
      ALUOP_SUB: ctl = SUB;
      ALUOP_RI: begin
        case (funct3)
          // sub only for R-type; addi reuses bit 30 as immediate
          FUNCT3_ADD:  ctl = (funct7b5 && opb5) ? SUB : ADD;
          FUNCT3_SLL:  ctl = SLL;
          FUNCT3_SLT:  ctl = SLT;
          FUNCT3_SLTU: ctl = SLTU;
          FUNCT3_XOR:  ctl = XOR;
          FUNCT3_SR:   ctl = funct7b5 ? SRA : SRL;
          FUNCT3_OR:   ctl = OR;
          default:     ctl = AND;
        endcase
      end
      default: begin
`ifdef ALU_GCD_LCM_EN
        if (funct3 == FUNCT3_GCD)      ctl = GCD;
        else if (funct3 == FUNCT3_LCM) ctl = LCM;
        else                           ctl = ILL;
`else
        ctl = ILL;
`endif
      end
    endcase
  end

endmodule

// File: rtl/alu_decode_exec.sv
// alu_decode_exec: decoded ALU with valid/ready handshake and optional
// iterative GCD/LCM.
//   clk, reset (async, active high)
//   in_valid/in_ready   - request handshake; ALUOp, funct3, funct7b5, opb5,
//                         srca, srcb form the request
//   out_valid/out_ready - result handshake; result, zero, illegal, ovf
// Single-cycle ops return one cycle after transfer and may issue back to
// back. GCD/LCM iterate one step per cycle and report through DONE.
// Build option: ALU_GCD_LCM_EN adds the GCD/LCM sequencer and ovf; without
// it ovf is tied 0 and the unit never leaves IDLE.
module alu_decode_exec
  import alu_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int MAX_ITER = 1024,
  parameter int ITER_W   = $clog2(MAX_ITER + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      ALUOp,
  input  logic [2:0]      funct3,
  input  logic            funct7b5,
  input  logic            opb5,
  input  logic [XLEN-1:0] srca,
  input  logic [XLEN-1:0] srcb,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal,
  output logic            ovf
);

  localparam int SHW = $clog2(XLEN);

  state_t          state;
  alu_ctl_t        ctl;
  logic            xfer;
  logic [SHW-1:0]  sh;
  logic [XLEN-1:0] alu_y;

  alu_ctl_dec u_dec (
    .aluop    (ALUOp),
    .funct3   (funct3),
    .funct7b5 (funct7b5),
    .opb5     (opb5),
    .ctl      (ctl)
  );

  assign in_ready = (state == S_IDLE) && (!out_valid || out_ready);
  assign xfer     = in_valid && in_ready;
  assign sh       = srcb[SHW-1:0];
  // qualified so the idle/reset state reads zero=0 even though result is 0
  assign zero     = out_valid && (result == '0);

  always_comb begin
    alu_y = '0;
    case (ctl)
      ADD:     alu_y = srca + srcb;
      SUB:     alu_y = srca - srcb;
      SLL:     alu_y = srca << sh;
      SLT:     alu_y = XLEN'($signed(srca) < $signed(srcb));
      SLTU:    alu_y = XLEN'(srca < srcb);
      XOR:     alu_y = srca ^ srcb;
      SRL:     alu_y = srca >> sh;
      SRA:     alu_y = $signed(srca) >>> sh;
      OR:      alu_y = srca | srcb;
      AND:     alu_y = srca & srcb;
      default: alu_y = '0;
    endcase
  end

`ifdef ALU_GCD_LCM_EN
  logic [XLEN-1:0]   a, b, ma, mb;
  logic [XLEN:0]     ma_sum, mb_sum;
  logic [ITER_W-1:0] iter;
  logic              fin, fin_ovf;
  logic [XLEN-1:0]   fin_res;

  assign ma_sum = {1'b0, ma} + {1'b0, a};
  assign mb_sum = {1'b0, mb} + {1'b0, b};

  // termination check for the current iteration; otherwise one step is taken
  always_comb begin
    fin     = 1'b0;
    fin_res = '0;
    fin_ovf = 1'b0;
    case (state)
      S_GCD: begin
        if (a == '0 || b == '0) begin
          fin = 1'b1; fin_res = a | b;
        end else if (iter == ITER_W'(MAX_ITER)) begin
          fin = 1'b1; fin_ovf = 1'b1;
        end else if (a == b) begin
          fin = 1'b1; fin_res = a;
        end
      end
      S_LCM: begin
        if (a == '0 || b == '0) begin
          fin = 1'b1;
        end else if (iter == ITER_W'(MAX_ITER)) begin
          fin = 1'b1; fin_ovf = 1'b1;
        end else if (ma == mb) begin
          fin = 1'b1; fin_res = ma;
        end else if ((ma < mb) ? ma_sum[XLEN] : mb_sum[XLEN]) begin
          fin = 1'b1; fin_ovf = 1'b1;
        end
      end
      default: ;
    endcase
  end
`else
  assign ovf = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      illegal   <= 1'b0;
`ifdef ALU_GCD_LCM_EN
      ovf       <= 1'b0;
      a         <= '0;
      b         <= '0;
      ma        <= '0;
      mb        <= '0;
      iter      <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          // retire the old result; a new transfer below may overwrite it
          if (out_valid && out_ready) out_valid <= 1'b0;
          if (xfer) begin
`ifdef ALU_GCD_LCM_EN
            if (ctl == GCD || ctl == LCM) begin
              a     <= srca;
              b     <= srcb;
              ma    <= srca;
              mb    <= srcb;
              iter  <= '0;
              state <= (ctl == GCD) ? S_GCD : S_LCM;
            end else begin
              out_valid <= 1'b1;
              result    <= alu_y;
              illegal   <= (ctl == ILL);
              ovf       <= 1'b0;
            end
`else
            out_valid <= 1'b1;
            result    <= alu_y;
            illegal   <= (ctl == ILL);
`endif
          end
        end
`ifdef ALU_GCD_LCM_EN
        S_GCD, S_LCM: begin
          if (fin) begin
            state     <= S_DONE;
            out_valid <= 1'b1;
            result    <= fin_res;
            illegal   <= 1'b0;
            ovf       <= fin_ovf;
          end else begin
            iter <= iter + 1'b1;
            if (state == S_GCD) begin
              if (a > b) a <= a - b;
              else       b <= b - a;
            end else begin
              if (ma < mb) ma <= ma_sum[XLEN-1:0];
              else         mb <= mb_sum[XLEN-1:0];
            end
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_decode_exec.sv
// tb_alu_decode_exec: directed-vector bench for alu_decode_exec (XLEN=32).
// GCD/LCM vectors are compiled in when ALU_GCD_LCM_EN is defined; otherwise
// the coprocessor ops are checked as illegal single-cycle ops.
module tb_alu_decode_exec;

  localparam int XLEN     = 32;
  localparam int MAX_ITER = 1024;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid, in_ready;
  logic [1:0]      ALUOp;
  logic [2:0]      funct3;
  logic            funct7b5, opb5;
  logic [XLEN-1:0] srca, srcb;
  logic            out_valid, out_ready;
  logic [XLEN-1:0] result;
  logic            zero, illegal, ovf;

  int err_cnt = 0;
  int chk_cnt = 0;

  alu_decode_exec #(.XLEN(XLEN), .MAX_ITER(MAX_ITER)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ALUOp     (ALUOp),
    .funct3    (funct3),
    .funct7b5  (funct7b5),
    .opb5      (opb5),
    .srca      (srca),
    .srcb      (srcb),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .illegal   (illegal),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Starts and ends on a negedge; holds in_valid until a transfer edge.
  task automatic send(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                      input logic o5, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    int n = 0;
    ALUOp = op; funct3 = f3; funct7b5 = f7; opb5 = o5; srca = a; srcb = b;
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("send_ready_timeout", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Single-cycle op: result must be valid at the first negedge after transfer.
  task automatic op1(input string tag, input logic [1:0] op, input logic [2:0] f3,
                     input logic f7, input logic o5, input logic [XLEN-1:0] a,
                     input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp,
                     input logic exp_ill);
    send(op, f3, f7, o5, a, b);
    chk({tag, ".valid"}, {63'd0, out_valid}, 64'd1);
    chk({tag, ".result"}, {32'd0, result}, {32'd0, exp});
    chk({tag, ".zero"}, {63'd0, zero}, {63'd0, (exp == '0)});
    chk({tag, ".illegal"}, {63'd0, illegal}, {63'd0, exp_ill});
  endtask

`ifdef ALU_GCD_LCM_EN
  // Multicycle op: returns number of negedge samples until out_valid.
  task automatic opm(input string tag, input logic [2:0] f3, input logic [XLEN-1:0] a,
                     input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp,
                     input logic exp_ovf, output int n);
    send(2'b11, f3, 1'b0, 1'b1, a, b);
    n = 1;
    while (!out_valid && n < MAX_ITER + 4) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ".valid"}, {63'd0, out_valid}, 64'd1);
    chk({tag, ".result"}, {32'd0, result}, {32'd0, exp});
    chk({tag, ".ovf"}, {63'd0, ovf}, {63'd0, exp_ovf});
    chk({tag, ".illegal"}, {63'd0, illegal}, 64'd0);
  endtask
`endif

  initial begin
    int n;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    ALUOp = '0; funct3 = '0; funct7b5 = 1'b0; opb5 = 1'b0; srca = '0; srcb = '0;
    repeat (2) @(negedge clk);
    chk("rst.out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst.result", {32'd0, result}, 64'd0);
    chk("rst.zero", {63'd0, zero}, 64'd0);
    chk("rst.illegal", {63'd0, illegal}, 64'd0);
    chk("rst.ovf", {63'd0, ovf}, 64'd0);
    chk("rst.in_ready", {63'd0, in_ready}, 64'd1);
    reset = 1'b0;
    @(negedge clk);

    // back-to-back single-cycle ops
    op1("sub_r",  2'b10, 3'b000, 1'b1, 1'b1, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0);
    op1("addi",   2'b10, 3'b000, 1'b1, 1'b0, 32'd5, 32'd7, 32'd12, 1'b0);
    op1("sra",    2'b10, 3'b101, 1'b1, 1'b1, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0);
    op1("srl",    2'b10, 3'b101, 1'b0, 1'b1, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0);
    op1("sll_msk",2'b10, 3'b001, 1'b0, 1'b1, 32'd1, 32'd63, 32'h8000_0000, 1'b0);
    op1("slt",    2'b10, 3'b010, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd5, 32'd1, 1'b0);
    op1("sltu",   2'b10, 3'b011, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd5, 32'd0, 1'b0);
    op1("xor",    2'b10, 3'b100, 1'b0, 1'b1, 32'hF0F0_1234, 32'h0FF0_1030, 32'hFF00_0204, 1'b0);
    op1("or",     2'b10, 3'b110, 1'b0, 1'b1, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1'b0);
    op1("and",    2'b10, 3'b111, 1'b0, 1'b1, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, 1'b0);
    op1("add00",  2'b00, 3'b111, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'd2, 32'd1, 1'b0);
    op1("sub01",  2'b01, 3'b000, 1'b0, 1'b0, 32'd9, 32'd9, 32'd0, 1'b0);

`ifdef ALU_GCD_LCM_EN
    opm("gcd0_9", 3'b000, 32'd0, 32'd9, 32'd9, 1'b0, n);
    chk("gcd0_9.lat", 64'(n), 64'd2);
    opm("gcd0_0", 3'b000, 32'd0, 32'd0, 32'd0, 1'b0, n);
    opm("lcm4_6", 3'b001, 32'd4, 32'd6, 32'd12, 1'b0, n);
    opm("lcm_carry", 3'b001, 32'h8000_0000, 32'hC000_0000, 32'd0, 1'b1, n);
    opm("lcm_tmo", 3'b001, 32'h8000_0000, 32'd3, 32'd0, 1'b1, n);

    // stall the GCD(48,18) result for 5 cycles
    out_ready = 1'b0;
    opm("gcd48_18", 3'b000, 32'd48, 32'd18, 32'd6, 1'b0, n);
    chk("gcd48_18.lat", 64'(n), 64'd6);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold.valid", {63'd0, out_valid}, 64'd1);
      chk("hold.result", {32'd0, result}, 64'd6);
      chk("hold.in_ready", {63'd0, in_ready}, 64'd0);
    end
    out_ready = 1'b1;
    op1("add_after", 2'b00, 3'b000, 1'b0, 1'b0, 32'd1, 32'd1, 32'd2, 1'b0);

    // reset in the middle of LCM(4,6)
    send(2'b11, 3'b001, 1'b0, 1'b1, 32'd4, 32'd6);
`else
    op1("cop_gcd_ill", 2'b11, 3'b000, 1'b0, 1'b1, 32'd48, 32'd18, 32'd0, 1'b1);
    chk("cop_gcd_ill.ovf", {63'd0, ovf}, 64'd0);
    op1("cop_lcm_ill", 2'b11, 3'b001, 1'b0, 1'b1, 32'd4, 32'd6, 32'd0, 1'b1);
    op1("add_after", 2'b00, 3'b000, 1'b0, 1'b0, 32'd1, 32'd1, 32'd2, 1'b0);
`endif
    #1 reset = 1'b1;
    #1;
    chk("midrst.out_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst.result", {32'd0, result}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst.in_ready", {63'd0, in_ready}, 64'd1);
    op1("cop_ill", 2'b11, 3'b111, 1'b0, 1'b1, 32'd5, 32'd3, 32'd0, 1'b1);
    chk("cop_ill.ovf", {63'd0, ovf}, 64'd0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/alu_decode_exec.md
Name: alu_decode_exec

Overview:
- Parametrised successor to the single-cycle ALU decoder. Decodes ALUOp/funct3/funct7b5/opb5 and executes the operation on XLEN-bit operands.
- Adds a registered valid/ready interface, shifts and unsigned compare, and an illegal-op flag.
- Adds iterative GCD/LCM ops on ALUOp=2'b11 for the coprocessor path.
- Sits between the register-file read stage and writeback in the multicycle datapath.

Parameters:
- XLEN, 32, operand/result width (≥8).
- MAX_ITER, 1024, iteration limit for GCD/LCM before timeout.
- ITER_W, $clog2(MAX_ITER+1), iteration counter width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request.
- ALUOp  in  2  00 add, 01 sub, 10 R/I-type decode, 11 coprocessor.
- funct3  in  3  instruction funct3.
- funct7b5  in  1  instruction bit 30.
- opb5  in  1  opcode bit 5 (R-type when 1).
- srca  in  XLEN  operand A.
- srcb  in  XLEN  operand B (shift amount = srcb[$clog2(XLEN)-1:0]).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  XLEN  result.
- zero  out  1  result == 0.
- illegal  out  1  undecodable op, qualified by out_valid.
- ovf  out  1  GCD/LCM overflow or timeout, qualified by out_valid.

Behaviour:
- Reset: state IDLE; out_valid=0, result=0, zero=0, illegal=0, ovf=0, iteration counter=0. Reset mid-operation aborts it; no result is produced.
- in_ready=1 only in IDLE when (!out_valid || out_ready). Transfer on in_valid && in_ready.
- Decode:
  - ALUOp 00 → add. ALUOp 01 → sub.
  - ALUOp 10, by funct3: 000 add, or sub when funct7b5&opb5; 001 sll; 010 slt (signed); 011 sltu; 100 xor; 101 srl, or sra when funct7b5; 110 or; 111 and.
  - ALUOp 11: funct3 000 GCD, 001 LCM; any other funct3 → illegal=1, result=0.
- Single-cycle ops: result registered, out_valid asserted the cycle after transfer (latency 1). State stays IDLE.
- FSM states IDLE, GCD, LCM, DONE.
- GCD: load a=srca, b=srcb (unsigned).
  - If a==0 or b==0: go to DONE next cycle with result = a|b.
  - Else, one step per cycle: a>b → a-=b; b>a → b-=a; a==b → DONE, result=a.
- LCM: if either operand is 0 → DONE, result=0. Else load ma=a, mb=b.
  - Each cycle: ma<mb → ma+=a; mb<ma → mb+=b; equal → DONE, result=ma.
  - Carry out of XLEN on any add → DONE with result=0, ovf=1.
- Iteration counter increments per GCD/LCM step. Reaching MAX_ITER → DONE with result=0, ovf=1.
- DONE: out_valid=1. Go to IDLE on the cycle the result is accepted (out_valid && out_ready). An input transfer is not allowed in that same cycle (in_ready=0 outside IDLE).
- IDLE with out_valid=1 and out_ready=1 and in_valid=1: old result retires and the new request is captured in the same cycle (back-to-back, 1 op/cycle for single-cycle ops).
- result, zero, illegal and ovf hold stable while out_valid && !out_ready.
- zero is computed from the registered result.

Optional Feature:
- Macro ALU_GCD_LCM_EN.
- Defined: GCD/LCM FSM states, iteration counter and ovf logic are present.
- Undefined: ALUOp 11 always gives illegal=1, result=0, latency 1; ovf is tied 0; FSM reduces to IDLE only.

Decomposition:
- alu_pkg holds:
  - alu_ctl_t enum (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, GCD, LCM, ILL);
  - ALUOP_* constants (2-bit);
  - FUNCT3_* constants;
  - state_t enum.
- Sub-module alu_ctl_dec: purely combinational decode to alu_ctl_t, reused by the single-cycle datapath.

Test Plan:
- XLEN=32. ALUOp=10, funct3=000, funct7b5=1, opb5=1, srca=5, srcb=7 → one cycle later out_valid=1, result=32'hFFFFFFFE, zero=0.
- ALUOp=10, funct3=101, funct7b5=1, srca=32'h80000000, srcb=4 → result=32'hF8000000. With funct7b5=0 → 32'h08000000.
- GCD srca=48, srcb=18 → result=6, ovf=0, out_valid within ≤MAX_ITER+2 cycles. GCD(0,9) → 9 in 2 cycles. GCD(0,0) → 0.
- LCM srca=4, srcb=6 → 12. LCM(32'h80000000, 3) → ovf=1, result=0.
- Hold out_ready=0 for 5 cycles after the GCD(48,18) result → result/out_valid stable and in_ready=0. Then out_ready=1 together with in_valid for an add 1+1 → add result 2 appears the next cycle.
- Assert reset mid-LCM(4,6) → out_valid=0 immediately; after release, in_ready=1. Then ALUOp=11, funct3=111 → illegal=1, result=0, zero=1.
